maxpool2d_k2s2_param: RTL and testbench

Parametrised 2x2, stride-2 pooling engine for the accelerator's depthwise-separable stages. It generalises the fixed 56x56x144 max-pool block to arbitrary height, width, channel count and signed data width, and adds a runtime-selectable average mode. It owns its input and output buffers. Input is loaded through a write port, computation starts on a one-cycle `start`, and results are read back by address once `done` is high.

---
 rtl/maxpool2d_k2s2_param.sv | 168 ++++++++++++++++
 tb/tb_maxpool2d_k2s2_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d_k2s2_param.sv
// rtl/maxpool2d_k2s2_param.sv - parametrised 2x2 stride-2 max/average pooling engine
// Owns its input/output buffers; one output every 5 cycles (4 window reads + 1 write).
module maxpool2d_k2s2_param #(
    parameter int DATA_W = 4,
    parameter int IN_H   = 56,
    parameter int IN_W   = 56,
    parameter int CH     = 144,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]        read_addr,
    output logic signed [DATA_W-1:0] read_data,
    output logic                     busy,
    output logic                     done
);
    localparam int OUT_H = IN_H / 2;
    localparam int OUT_W = IN_W / 2;
    localparam int IN_N  = CH * IN_H * IN_W;
    localparam int OUT_N = CH * OUT_H * OUT_W;
    localparam int AW    = DATA_W + 2;
    localparam int IW    = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int OW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam int XW    = $clog2(OUT_W + 1);
    localparam int YW    = $clog2(OUT_H + 1);
    localparam int CW    = $clog2(CH + 1);

    localparam logic [XW-1:0]     X_LAST  = XW'(OUT_W - 1);
    localparam logic [YW-1:0]     Y_LAST  = YW'(OUT_H - 1);
    localparam logic [CW-1:0]     C_LAST  = CW'(CH - 1);
    localparam logic [ADDR_W-1:0] A_IN_N  = ADDR_W'(IN_N);
    localparam logic [ADDR_W-1:0] A_OUT_N = ADDR_W'(OUT_N);
    localparam logic [ADDR_W-1:0] A_IN_W  = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] A_ROW2  = ADDR_W'(2 * IN_W);
    localparam logic [ADDR_W-1:0] A_PLANE = ADDR_W'(IN_H * IN_W);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t                     r_state, w_next;
    logic [1:0]                 r_k;
    logic [XW-1:0]              r_ox;
    logic [YW-1:0]              r_oy;
    logic [CW-1:0]              r_c;
    logic [ADDR_W-1:0]          r_row_base;
    logic [ADDR_W-1:0]          r_ch_base;
    logic [OW-1:0]              r_out_idx;
    logic                       r_mode;
    logic signed [AW-1:0]       r_acc;
    logic signed [DATA_W-1:0]   r_rd_data;
    logic signed [DATA_W-1:0]   r_read_data;
    logic signed [DATA_W-1:0]   r_in_buf  [IN_N];
    logic signed [DATA_W-1:0]   r_out_buf [OUT_N];

    logic [ADDR_W-1:0]          w_rd_addr;
    logic signed [AW-1:0]       w_elem;
    logic signed [AW-1:0]       w_fold;
    logic signed [AW-1:0]       w_avg;
    logic signed [DATA_W-1:0]   w_result;
    logic                       w_last_out;

    assign busy      = (r_state == S_RD) || (r_state == S_WR);
    assign done      = (r_state == S_DONE);
    assign read_data = r_read_data;

    // Window element k: bit 1 selects the lower row, bit 0 the right column.
    assign w_rd_addr  = r_row_base + ADDR_W'({r_ox, 1'b0}) + (r_k[1] ? A_IN_W : '0)
                      + ADDR_W'(r_k[0]);
    assign w_last_out = (r_ox == X_LAST) && (r_oy == Y_LAST) && (r_c == C_LAST);
    assign w_elem     = {{2{r_rd_data[DATA_W-1]}}, r_rd_data};

    always_comb begin
        w_fold = r_acc;
        if (r_state == S_RD && r_k == 2'd1) begin
            w_fold = w_elem;
        end else if (r_mode) begin
            w_fold = r_acc + w_elem;
        end else if (w_elem > r_acc) begin
            w_fold = w_elem;
        end
    end

    assign w_avg    = w_fold >>> 2;
    assign w_result = r_mode ? w_avg[DATA_W-1:0] : w_fold[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_RD;
            S_RD:           if (r_k == 2'd3) w_next = S_WR;
            S_WR:           w_next = w_last_out ? S_DONE : S_RD;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_k        <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_c        <= '0;
            r_row_base <= '0;
            r_ch_base  <= '0;
            r_out_idx  <= '0;
            r_mode     <= 1'b0;
            r_acc      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_k        <= '0;
                        r_ox       <= '0;
                        r_oy       <= '0;
                        r_c        <= '0;
                        r_row_base <= '0;
                        r_ch_base  <= '0;
                        r_out_idx  <= '0;
                        r_mode     <= mode;
                    end
                end
                S_RD: begin
                    r_k <= r_k + 2'd1;
                    if (r_k != 2'd0) r_acc <= w_fold;
                end
                S_WR: begin
                    r_k       <= '0;
                    r_out_idx <= r_out_idx + 1'b1;
                    if (r_ox != X_LAST) begin
                        r_ox <= r_ox + 1'b1;
                    end else begin
                        r_ox <= '0;
                        if (r_oy != Y_LAST) begin
                            r_oy       <= r_oy + 1'b1;
                            r_row_base <= r_row_base + A_ROW2;
                        end else begin
                            r_oy       <= '0;
                            r_c        <= r_c + 1'b1;
                            r_ch_base  <= r_ch_base + A_PLANE;
                            r_row_base <= r_ch_base + A_PLANE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !busy && wr_addr < A_IN_N) r_in_buf[wr_addr[IW-1:0]] <= wr_data;
        r_rd_data <= r_in_buf[w_rd_addr[IW-1:0]];
        if (r_state == S_WR) r_out_buf[r_out_idx] <= w_result;
    end

    always_ff @(posedge clk) begin
        if (!resetn)                  r_read_data <= '0;
        else if (read_addr < A_OUT_N) r_read_data <= r_out_buf[read_addr[OW-1:0]];
        else                          r_read_data <= '0;
    end
endmodule

// File: tb/tb_maxpool2d_k2s2_param.sv
// tb/tb_maxpool2d_k2s2_param.sv - self-checking bench for maxpool2d_k2s2_param
// Instance a: 4x4x2 (OUT_N=8); instance o: 5x3x1 odd dimensions (OUT_N=2).
module tb_maxpool2d_k2s2_param;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic               a_start = 0, a_mode = 0, a_wr_en = 0;
    logic [31:0]        a_wr_addr = 0, a_raddr = 0;
    logic signed [3:0]  a_wr_data = 0, a_rdata;
    logic               a_busy, a_done;
    logic               o_start = 0, o_mode = 0, o_wr_en = 0;
    logic [31:0]        o_wr_addr = 0, o_raddr = 0;
    logic signed [3:0]  o_wr_data = 0, o_rdata;
    logic               o_busy, o_done;

    maxpool2d_k2s2_param #(.DATA_W(4), .IN_H(4), .IN_W(4), .CH(2), .ADDR_W(32)) dut_a (
        .clk(clk), .resetn(resetn), .start(a_start), .mode(a_mode), .wr_en(a_wr_en),
        .wr_addr(a_wr_addr), .wr_data(a_wr_data), .read_addr(a_raddr),
        .read_data(a_rdata), .busy(a_busy), .done(a_done));

    maxpool2d_k2s2_param #(.DATA_W(4), .IN_H(5), .IN_W(3), .CH(1), .ADDR_W(32)) dut_o (
        .clk(clk), .resetn(resetn), .start(o_start), .mode(o_mode), .wr_en(o_wr_en),
        .wr_addr(o_wr_addr), .wr_data(o_wr_data), .read_addr(o_raddr),
        .read_data(o_rdata), .busy(o_busy), .done(o_done));

    typedef struct { bit md; int e0; int e1; int e2; int e3; int exp; } win_t;

    int n_tests = 0;
    int n_fail  = 0;
    int ma[32];
    int mo[15];
    int sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_out(input bit sel, input bit md, input int idx);
        int h, w, oh, ow, c, oy, ox, v, s, m;
        h = sel ? 5 : 4;
        w = sel ? 3 : 4;
        oh = h / 2;
        ow = w / 2;
        ox = idx % ow;
        oy = (idx / ow) % oh;
        c  = idx / (ow * oh);
        s = 0;
        m = -1000;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = sel ? mo[(c*h + 2*oy + dy)*w + 2*ox + dx] : ma[(c*h + 2*oy + dy)*w + 2*ox + dx];
                s += v;
                if (v > m) m = v;
            end
        end
        if (!md) return m;
        return (s >= 0) ? s / 4 : -((-s + 3) / 4);
    endfunction

    // All tasks are entered and left on a falling edge.
    task automatic wr(input bit sel, input int addr, input int val);
        if (sel) begin o_wr_en = 1; o_wr_addr = addr; o_wr_data = 4'(val); end
        else     begin a_wr_en = 1; a_wr_addr = addr; a_wr_data = 4'(val); end
        @(negedge clk);
        a_wr_en = 0;
        o_wr_en = 0;
    endtask

    task automatic ld(input bit sel, input int addr, input int val);
        wr(sel, addr, val);
        if (sel) mo[addr] = val;
        else     ma[addr] = val;
    endtask

    task automatic rd(input bit sel, input logic [31:0] addr, input int exp, input string nm);
        sb.push_back(exp);
        if (sel) o_raddr = addr;
        else     a_raddr = addr;
        @(negedge clk);
        chk(nm, sel ? int'(o_rdata) : int'(a_rdata), sb.pop_front());
    endtask

    task automatic run(input bit sel, input bit md, input int mid_at, input int rst_at,
                       input int sw_addr, input int sw_data, input string nm);
        int cnt, bcnt, nexp;
        nexp = sel ? 10 : 40;
        if (sel) begin o_start = 1; o_mode = md; end
        else     begin a_start = 1; a_mode = md; end
        if (sw_addr >= 0) begin a_wr_en = 1; a_wr_addr = sw_addr; a_wr_data = 4'(sw_data); end
        @(negedge clk);
        a_start = 0; o_start = 0; a_wr_en = 0;
        cnt = 0;
        bcnt = 0;
        while (!(sel ? o_done : a_done) && cnt < nexp + 20) begin
            if (sel ? o_busy : a_busy) bcnt++;
            if (cnt == mid_at) begin
                a_start = 1; a_mode = ~md; a_wr_en = 1; a_wr_addr = 31; a_wr_data = -4'sd8;
            end else begin
                a_start = 0; a_wr_en = 0;
            end
            if (cnt == rst_at) begin
                resetn = 0;
                @(negedge clk);
                resetn = 1;
                a_start = 0; a_wr_en = 0;
                chk({nm, " rst busy"}, int'(a_busy), 0);
                chk({nm, " rst done"}, int'(a_done), 0);
                chk({nm, " rst read_data"}, int'(a_rdata), 0);
                return;
            end
            @(negedge clk);
            cnt++;
        end
        a_start = 0; a_wr_en = 0;
        chk({nm, " done cycle"}, cnt, nexp);
        chk({nm, " busy cycles"}, bcnt, nexp);
        chk({nm, " busy at done"}, int'(sel ? o_busy : a_busy), 0);
    endtask

    task automatic read_all(input bit sel, input bit md, input string nm);
        for (int i = 0; i < (sel ? 2 : 8); i++)
            rd(sel, i, ref_out(sel, md, i), $sformatf("%s out%0d", nm, i));
    endtask

    initial begin
        win_t tbl[10];
        int keep0, keep1;
        tbl[0] = '{1'b0, -8, -7, -4, -3, -3};
        tbl[1] = '{1'b1, -8, -7, -4, -3, -6};
        tbl[2] = '{1'b1, -8, -8, -8, -8, -8};
        tbl[3] = '{1'b1,  7,  7,  7,  7,  7};
        tbl[4] = '{1'b0, -8, -8, -8, -8, -8};
        tbl[5] = '{1'b0,  7, -8, -8, -8,  7};
        tbl[6] = '{1'b0, -8, -8, -8,  7,  7};
        tbl[7] = '{1'b1,  1,  0,  0,  0,  0};
        tbl[8] = '{1'b1, -1,  0,  0,  0, -1};
        tbl[9] = '{1'b0, -1, -2, -3, -4, -1};

        repeat (3) @(negedge clk);
        chk("reset a busy", int'(a_busy), 0);
        chk("reset a done", int'(a_done), 0);
        chk("reset a read_data", int'(a_rdata), 0);
        chk("reset o busy", int'(o_busy), 0);
        chk("reset o done", int'(o_done), 0);
        chk("reset o read_data", int'(o_rdata), 0);
        resetn = 1;
        @(negedge clk);

        for (int i = 0; i < 32; i++) ld(0, i, (i % 16) - 8);
        run(0, 0, -1, -1, -1, 0, "max");
        rd(0, 0, -3, "max out0 const");
        read_all(0, 0, "max");
        run(0, 1, -1, -1, -1, 0, "avg");
        rd(0, 0, -6, "avg out0 const");
        read_all(0, 1, "avg");
        rd(0, 8, 0, "read OUT_N");
        rd(0, 32'hFFFF_FFFF, 0, "read far");

        run(0, 0, 7, -1, -1, 0, "mid start+wr");
        read_all(0, 0, "mid start+wr");
        wr(0, 32, 7);
        run(0, 0, -1, -1, -1, 0, "oob wr");
        rd(0, 0, -3, "oob wr out0");
        run(0, 0, -1, -1, 0, 7, "start+wr");
        ma[0] = 7;
        rd(0, 0, 7, "start+wr out0");
        read_all(0, 0, "start+wr");
        ld(0, 0, -8);

        run(0, 1, -1, 13, -1, 0, "midrst");
        run(0, 1, -1, -1, -1, 0, "after rst");
        read_all(0, 1, "after rst");

        for (int t = 0; t < 10; t++) begin
            ld(0, 0, tbl[t].e0);
            ld(0, 1, tbl[t].e1);
            ld(0, 4, tbl[t].e2);
            ld(0, 5, tbl[t].e3);
            run(0, tbl[t].md, -1, -1, -1, 0, $sformatf("win%0d", t));
            rd(0, 0, tbl[t].exp, $sformatf("win%0d out0", t));
        end

        for (int i = 0; i < 15; i++) ld(1, i, int'($urandom_range(15)) - 8);
        run(1, 0, -1, -1, -1, 0, "odd max");
        keep0 = ref_out(1, 0, 0);
        keep1 = ref_out(1, 0, 1);
        read_all(1, 0, "odd max");
        for (int i = 12; i < 15; i++) ld(1, i, (mo[i] + 9) % 16 - 8 + ((mo[i] + 9) % 16 < 0 ? 16 : 0));
        for (int y = 0; y < 4; y++) ld(1, y*3 + 2, 7);
        run(1, 0, -1, -1, -1, 0, "odd edit");
        rd(1, 0, keep0, "odd edit out0");
        rd(1, 1, keep1, "odd edit out1");
        run(1, 1, -1, -1, -1, 0, "odd avg");
        read_all(1, 1, "odd avg");
        rd(1, 2, 0, "odd read OUT_N");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
